// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_pkg
// Purpose  : Shared definitions for the pipeline hazard controller: PCSrc
//            encodings produced by the decoder, controller FSM states and the
//            hard-wired zero register index.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    // Decoder PCSrc encodings
    localparam logic [2:0] c_PCSRC_SEQ  = 3'b000;
    localparam logic [2:0] c_PCSRC_BR   = 3'b001;
    localparam logic [2:0] c_PCSRC_J    = 3'b010;
    localparam logic [2:0] c_PCSRC_JR   = 3'b011;
    localparam logic [2:0] c_PCSRC_JALR = 3'b110;

    // Register $zero is never a real producer, so it never creates a hazard
    localparam logic [4:0] c_REG_ZERO = 5'd0;

    // Controller states
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_IRQ_HOLD = 2'd2
    } state_t;

endpackage : hazard_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_if
// Purpose  : Signal bundle between the pipeline datapath and the hazard
//            controller.
//            master : pipeline side (drives decoded fields, memory status,
//                     irq; receives enables/flushes/freeze/irq_take)
//            slave  : hazard controller side
//            Optional: stall_cycles (32-bit) when HAZARD_PERF_CNT_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [2:0] id_pcsrc;
    logic       ex_memread;
    logic       ex_regwrite;
    logic [4:0] ex_dst;
    logic       mem_memread;
    logic [4:0] mem_dst;
    logic       ex_branch_taken;
    logic       dmem_req;
    logic       dmem_ready;
    logic       irq;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       freeze;
    logic       irq_take;
    logic       mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    modport master (
        output id_rs, id_rt, id_pcsrc, ex_memread, ex_regwrite, ex_dst,
               mem_memread, mem_dst, ex_branch_taken, dmem_req, dmem_ready, irq,
`ifdef HAZARD_PERF_CNT_EN
        input  stall_cycles,
`endif
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, freeze,
               irq_take, mem_timeout
    );

    modport slave (
        input  id_rs, id_rt, id_pcsrc, ex_memread, ex_regwrite, ex_dst,
               mem_memread, mem_dst, ex_branch_taken, dmem_req, dmem_ready, irq,
`ifdef HAZARD_PERF_CNT_EN
        output stall_cycles,
`endif
        output pc_write, if_id_write, if_id_flush, id_ex_flush, freeze,
               irq_take, mem_timeout
    );
endinterface : hazard_ctrl_if
`default_nettype wire

// File: rtl/hazard_ctrl_cmp.sv
`default_nettype none
// ============================================================================
// Module   : hazard_cmp
// Purpose  : Combinational match of one producer destination register against
//            the rs (and optionally rt) source of the instruction in ID.
//            The zero register never matches.
// Ports    : i_dst    producer destination register
//            i_rs     ID rs field
//            i_rt     ID rt field
//            i_useRt  include rt in the comparison
//            o_match  producer feeds an ID source operand
// Revision : 1.0 - initial release
// ============================================================================
module hazard_cmp
    import hazard_ctrl_pkg::*;
(
    input  wire logic [4:0] i_dst,
    input  wire logic [4:0] i_rs,
    input  wire logic [4:0] i_rt,
    input  wire logic       i_useRt,
    output logic            o_match
);

    logic w_live;

    assign w_live  = (i_dst != c_REG_ZERO);
    assign o_match = w_live && ((i_dst == i_rs) || (i_useRt && (i_dst == i_rt)));

endmodule : hazard_cmp
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline sequencing controller for the 5-stage MIPS core.
//            Generates PC / IF-ID enables, stage flushes, global freeze for
//            slow data memory (with wait timeout) and interrupt acceptance
//            with a post-interrupt hold-off.
// Ports    : clk, reset (asynchronous, active-high)
//            bus : hazard_ctrl_if.slave (decoded fields in, controls out)
// Params   : IRQ_HOLDOFF  cycles irq is ignored after acceptance (1..15)
//            MEM_TIMEOUT  max consecutive dmem wait cycles (1..255)
// Options  : HAZARD_PERF_CNT_EN adds the 32-bit stall_cycles counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int IRQ_HOLDOFF = 4,
    parameter int MEM_TIMEOUT = 255
)
(
    input  wire logic   clk,
    input  wire logic   reset,
    hazard_ctrl_if.slave bus
);

    localparam logic [3:0] c_HOLD_INIT = 4'(IRQ_HOLDOFF - 1);
    localparam logic [7:0] c_TIMEOUT   = 8'(MEM_TIMEOUT);

    state_t     r_state,   w_stateNxt;
    logic [7:0] r_waitCnt, w_waitCntNxt;
    logic [3:0] r_holdCnt, w_holdCntNxt;

    logic w_loadUseMatch, w_jrExMatch, w_jrMemMatch;
    logic w_isJr, w_isJump, w_memBusy, w_timeoutHit, w_freeze;
    logic w_stall, w_irqAccept;
    logic w_pcWrite, w_ifIdWrite, w_ifIdFlush, w_idExFlush;
    logic w_freezeOut, w_irqTake, w_memTimeout;

    // One comparator per hazard source
    hazard_cmp u_loadUseCmp (
        .i_dst   (bus.ex_dst),
        .i_rs    (bus.id_rs),
        .i_rt    (bus.id_rt),
        .i_useRt (1'b1),
        .o_match (w_loadUseMatch)
    );

    hazard_cmp u_jrExCmp (
        .i_dst   (bus.ex_dst),
        .i_rs    (bus.id_rs),
        .i_rt    (bus.id_rt),
        .i_useRt (1'b0),
        .o_match (w_jrExMatch)
    );

    hazard_cmp u_jrMemCmp (
        .i_dst   (bus.mem_dst),
        .i_rs    (bus.id_rs),
        .i_rt    (bus.id_rt),
        .i_useRt (1'b0),
        .o_match (w_jrMemMatch)
    );

    assign w_isJr   = (bus.id_pcsrc == c_PCSRC_JR) || (bus.id_pcsrc == c_PCSRC_JALR);
    assign w_isJump = w_isJr || (bus.id_pcsrc == c_PCSRC_J);

    // The timeout only applies to a wait entered from RUN; a freeze seen in
    // IRQ_HOLD simply holds until memory answers.
    assign w_memBusy    = bus.dmem_req && !bus.dmem_ready;
    assign w_timeoutHit = (r_state == ST_MEM_WAIT) && (r_waitCnt == c_TIMEOUT);
    assign w_freeze     = w_memBusy && !w_timeoutHit;

    // jr/jalr read rs in ID, so an ALU result still in EX or a load still in
    // MEM is not yet available to them.
    assign w_stall = (bus.ex_memread && w_loadUseMatch) ||
                     (w_isJr && ((bus.ex_regwrite && w_jrExMatch) ||
                                 (bus.mem_memread && w_jrMemMatch)));

    // Only accept on a sequential instruction so the saved EPC is unambiguous
    assign w_irqAccept = (r_state == ST_RUN) && bus.irq && !w_freeze &&
                         !bus.ex_branch_taken && (bus.id_pcsrc == c_PCSRC_SEQ);

    // ------------------------------------------------------------------
    // Output decode, highest priority first
    // ------------------------------------------------------------------
    always_comb begin
        w_pcWrite    = 1'b1;
        w_ifIdWrite  = 1'b1;
        w_ifIdFlush  = 1'b0;
        w_idExFlush  = 1'b0;
        w_freezeOut  = 1'b0;
        w_irqTake    = 1'b0;
        w_memTimeout = 1'b0;
        if (reset) begin
            w_pcWrite   = 1'b0;
            w_ifIdWrite = 1'b0;
            w_ifIdFlush = 1'b1;
            w_idExFlush = 1'b1;
        end else if (w_freeze) begin
            w_freezeOut = 1'b1;
            w_pcWrite   = 1'b0;
            w_ifIdWrite = 1'b0;
        end else begin
            w_memTimeout = w_memBusy && w_timeoutHit;
            if (bus.ex_branch_taken) begin
                w_ifIdFlush = 1'b1;
                w_idExFlush = 1'b1;
            end else if (w_irqAccept) begin
                w_irqTake   = 1'b1;
                w_ifIdFlush = 1'b1;
            end else if (w_stall) begin
                w_pcWrite   = 1'b0;
                w_ifIdWrite = 1'b0;
                w_idExFlush = 1'b1;
            end else if (w_isJump) begin
                w_ifIdFlush = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNxt   = r_state;
        w_waitCntNxt = r_waitCnt;
        w_holdCntNxt = r_holdCnt;
        case (r_state)
            ST_RUN: begin
                if (w_freeze) begin
                    w_stateNxt   = ST_MEM_WAIT;
                    w_waitCntNxt = 8'd0;
                end else if (w_irqAccept) begin
                    w_stateNxt   = ST_IRQ_HOLD;
                    w_holdCntNxt = c_HOLD_INIT;
                end
            end
            ST_MEM_WAIT: begin
                // Any unfrozen cycle (ready, timeout or request withdrawn)
                // ends the wait.
                if (w_freeze) begin
                    w_waitCntNxt = r_waitCnt + 8'd1;
                end else begin
                    w_stateNxt   = ST_RUN;
                    w_waitCntNxt = 8'd0;
                end
            end
            ST_IRQ_HOLD: begin
                if (!w_freeze) begin
                    if (r_holdCnt == 4'd0) begin
                        w_stateNxt = ST_RUN;
                    end else begin
                        w_holdCntNxt = r_holdCnt - 4'd1;
                    end
                end
            end
            default: begin
                w_stateNxt   = ST_RUN;
                w_waitCntNxt = 8'd0;
                w_holdCntNxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_waitCnt <= 8'd0;
            r_holdCnt <= 4'd0;
        end else begin
            r_state   <= w_stateNxt;
            r_waitCnt <= w_waitCntNxt;
            r_holdCnt <= w_holdCntNxt;
        end
    end

    assign bus.pc_write    = w_pcWrite;
    assign bus.if_id_write = w_ifIdWrite;
    assign bus.if_id_flush = w_ifIdFlush;
    assign bus.id_ex_flush = w_idExFlush;
    assign bus.freeze      = w_freezeOut;
    assign bus.irq_take    = w_irqTake;
    assign bus.mem_timeout = w_memTimeout;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stallCycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stallCycles <= 32'd0;
        end else if (!w_pcWrite) begin
            r_stallCycles <= r_stallCycles + 32'd1;
        end
    end

    assign bus.stall_cycles = r_stallCycles;
`endif

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4,
//            IRQ_HOLDOFF=4). Outputs are packed as
//            {pc_write, if_id_write, if_id_flush, id_ex_flush, freeze,
//             irq_take, mem_timeout}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam logic [6:0] c_RST = 7'b0011000;
    localparam logic [6:0] c_DEF = 7'b1100000;
    localparam logic [6:0] c_STL = 7'b0001000;
    localparam logic [6:0] c_BRF = 7'b1111000;
    localparam logic [6:0] c_JMP = 7'b1110000;
    localparam logic [6:0] c_FRZ = 7'b0000100;
    localparam logic [6:0] c_IRQ = 7'b1110010;
    localparam logic [6:0] c_TMO = 7'b1100001;

    logic clk;
    logic reset;
    int   vectors;
    int   errs;

    hazard_ctrl_if hif ();

    hazard_ctrl #(
        .IRQ_HOLDOFF (4),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {hif.pc_write, hif.if_id_write, hif.if_id_flush, hif.id_ex_flush,
                hif.freeze, hif.irq_take, hif.mem_timeout};
    endfunction

    task automatic check(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        #1;
        obs = outs();
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkState(input string tag, input state_t exp);
        logic [1:0] obs;
        obs = dut.r_state;
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        reset   = 1'b1;
        hif.id_rs = 5'd0; hif.id_rt = 5'd0; hif.id_pcsrc = c_PCSRC_SEQ;
        hif.ex_memread = 1'b0; hif.ex_regwrite = 1'b0; hif.ex_dst = 5'd0;
        hif.mem_memread = 1'b0; hif.mem_dst = 5'd0; hif.ex_branch_taken = 1'b0;
        hif.dmem_req = 1'b0; hif.dmem_ready = 1'b0; hif.irq = 1'b0;

        check("reset_outputs", c_RST);
        tick();
        reset = 1'b0;
        check("idle", c_DEF);
        checkState("idle_state", ST_RUN);

        // Load-use
        hif.ex_memread = 1'b1; hif.ex_dst = 5'd8; hif.id_rs = 5'd8;
        check("loaduse_rs", c_STL);
        tick();
        hif.ex_memread = 1'b0;
        check("loaduse_released", c_DEF);
        tick();
        hif.ex_memread = 1'b1; hif.ex_dst = 5'd0; hif.id_rs = 5'd0;
        check("loaduse_r0", c_DEF);
        tick();
        hif.ex_dst = 5'd9; hif.id_rt = 5'd9; hif.id_rs = 5'd3;
        check("loaduse_rt", c_STL);
        tick();
        hif.ex_memread = 1'b0; hif.ex_dst = 5'd0; hif.id_rt = 5'd0; hif.id_rs = 5'd0;

        // jr / jalr hazards
        hif.id_pcsrc = c_PCSRC_JR; hif.id_rs = 5'd31;
        hif.ex_regwrite = 1'b1; hif.ex_dst = 5'd31;
        check("jr_ex_stall", c_STL);
        tick();
        hif.ex_regwrite = 1'b0; hif.ex_dst = 5'd0;
        check("jr_flush", c_JMP);
        tick();
        hif.id_pcsrc = c_PCSRC_JALR; hif.mem_memread = 1'b1; hif.mem_dst = 5'd31;
        check("jalr_mem_stall", c_STL);
        tick();
        hif.mem_memread = 1'b0; hif.mem_dst = 5'd0;
        hif.id_pcsrc = c_PCSRC_J; hif.ex_regwrite = 1'b1; hif.ex_dst = 5'd31;
        check("j_no_stall", c_JMP);
        tick();
        hif.id_pcsrc = c_PCSRC_SEQ; hif.ex_regwrite = 1'b0; hif.ex_dst = 5'd0;

        // Branch beats load-use stall
        hif.ex_branch_taken = 1'b1; hif.ex_memread = 1'b1;
        hif.ex_dst = 5'd8; hif.id_rs = 5'd8;
        check("branch_over_stall", c_BRF);
        tick();
        hif.ex_branch_taken = 1'b0; hif.ex_memread = 1'b0;
        hif.ex_dst = 5'd0; hif.id_rs = 5'd0;

        // Memory wait of 3 cycles
        hif.dmem_req = 1'b1; hif.dmem_ready = 1'b0;
        check("memwait_c1", c_FRZ);
        tick();
        hif.ex_branch_taken = 1'b1;
        check("memwait_c2_over_branch", c_FRZ);
        tick();
        hif.ex_branch_taken = 1'b0;
        check("memwait_c3", c_FRZ);
        tick();
        hif.dmem_ready = 1'b1;
        check("memwait_ready", c_DEF);
        tick();
        hif.dmem_req = 1'b0; hif.dmem_ready = 1'b0;
        checkState("memwait_back_run", ST_RUN);
        check("memwait_after", c_DEF);
        tick();

        // Timeout: 5 frozen cycles then a pulse with freeze low
        hif.dmem_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("timeout_frz%0d", i + 1), c_FRZ);
            tick();
        end
        check("timeout_pulse", c_TMO);
        tick();
        checkState("timeout_back_run", ST_RUN);
        check("timeout_rewait", c_FRZ);
        tick();
        hif.dmem_req = 1'b0;
        tick();

        // Interrupts: branch first, then retry, hold-off, re-take
        hif.irq = 1'b1; hif.ex_branch_taken = 1'b1;
        check("irq_vs_branch", c_BRF);
        tick();
        hif.ex_branch_taken = 1'b0;
        check("irq_take1", c_IRQ);
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("irq_hold_a%0d", i + 1), c_DEF);
            tick();
        end
        check("irq_take2", c_IRQ);
        tick();
        // Freeze in IRQ_HOLD pauses the count and never times out
        hif.dmem_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("irq_hold_frz%0d", i + 1), c_FRZ);
            tick();
        end
        hif.dmem_req = 1'b0;
        checkState("irq_hold_kept", ST_IRQ_HOLD);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("irq_hold_b%0d", i + 1), c_DEF);
            tick();
        end
        check("irq_take3", c_IRQ);
        tick();
        check("irq_hold_c1", c_DEF);
        // Reset mid-hold returns straight to RUN
        reset = 1'b1;
        check("irq_reset_outputs", c_RST);
        checkState("irq_reset_state", ST_RUN);
        tick();
        reset = 1'b0;
        check("irq_after_reset", c_IRQ);
        tick();
        hif.irq = 1'b0;
        tick();
        check("final_idle", c_DEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire
